// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg
//   Shared types and default parameters for the pulse width meter.
//   pwm_state_t   : FSM state encoding (IDLE, MEASURE, WAIT_LOW)
//   PWM_CNT_W     : default counter / width output size
//   PWM_MIN_WIDTH : default shortest accepted pulse, in cycles
//   PWM_MAX_WIDTH : default saturation limit, in cycles
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        WAIT_LOW = 2'd2
    } pwm_state_t;

    localparam int PWM_CNT_W     = 22;
    localparam int PWM_MIN_WIDTH = 4;
    localparam int PWM_MAX_WIDTH = 2550000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock
//   rst : synchronous reset, active high; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Measures the width, in clk cycles, of each high pulse on measurein.
//   Pulses shorter than MIN_WIDTH are dropped; pulses longer than
//   MAX_WIDTH are reported as MAX_WIDTH with overflow set, and the rest
//   of such a pulse is ignored.
//   clk       : system clock
//   rst       : synchronous reset, active high
//   measurein : asynchronous pulse input
//   width     : last reported width, held between reports
//   valid     : one-cycle strobe marking a new width
//   overflow  : one-cycle strobe with valid when the pulse saturated
//   busy      : high while measuring or waiting for an overflowed pulse to end
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a rising edge of the synchronized input
//   MEASURE  | counting high cycles of the current pulse
//   WAIT_LOW | pulse saturated and reported; waiting for the input to drop
module pulse_width_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W     = PWM_CNT_W,
    parameter int MIN_WIDTH = PWM_MIN_WIDTH,
    parameter int MAX_WIDTH = PWM_MAX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             measurein,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

    logic             s2;
    logic             s2_d;
    logic             rise;

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_d;
    logic             valid_d;
    logic             overflow_d;

    // Reset value 1 on the whole input chain means a line that is already
    // high when reset releases looks like a steady level, not an edge.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (measurein),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_d <= 1'b1;
        end else begin
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            width    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width    <= width_d;
            valid    <= valid_d;
            overflow <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        width_d    = width;
        valid_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (s2) begin
                    // Still high after MAX_WIDTH counted cycles: saturate.
                    // Leaving MEASURE here is what keeps cnt from wrapping.
                    if (cnt_q == MAX_C) begin
                        width_d    = MAX_C;
                        valid_d    = 1'b1;
                        overflow_d = 1'b1;
                        state_d    = WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q >= MIN_C) begin
                        width_d = cnt_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!s2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Measures the width, in clock cycles, of each high pulse on a single asynchronous input line and reports it as a one-cycle strobe plus a width word. It is the receiving counterpart to the pulse stretcher in the serial/sensor path. It turns stretched or sensor-generated pulses back into numbers that the Wishbone-side logic reads. Short glitches are rejected, and over-long pulses saturate and are flagged.

## Interface
- CNT_W, 22: width of the counter and of the `width` output.
- MIN_WIDTH, 4: minimum accepted pulse width in cycles; shorter pulses are discarded silently. Must be ≥1.
- MAX_WIDTH, 2550000: saturation limit in cycles. Must be < 2^CNT_W and ≥ MIN_WIDTH.
- clk, in, 1: single system clock; everything is on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- measurein, in, 1: asynchronous pulse input.
- width, out, CNT_W: last measured width; holds its value until the next report.
- valid, out, 1: one-cycle strobe that marks a new `width`.
- overflow, out, 1: one-cycle strobe, coincident with `valid`, when the pulse exceeded MAX_WIDTH.
- busy, out, 1: high while a pulse is being measured or awaited low (state ≠ IDLE).

## Operation
- Input conditioning:
  - `measurein` passes through a 2-FF synchronizer, giving `s2`.
  - One further register `s2_d` holds the previous sample.
  - rise = `s2` & !`s2_d`.
- FSM states: IDLE, MEASURE, WAIT_LOW.
- IDLE:
  - On rise: `cnt`←1, go to MEASURE.
  - Otherwise stay. A steady high level never starts a measurement; a rising edge is always required.
- MEASURE, `s2`=1 and `cnt`<MAX_WIDTH: `cnt`←`cnt`+1.
- MEASURE, `s2`=1 and `cnt`==MAX_WIDTH:
  - `width`←MAX_WIDTH, `valid`=1, `overflow`=1.
  - Go to WAIT_LOW.
- MEASURE, `s2`=0:
  - If `cnt`≥MIN_WIDTH: `width`←`cnt`, `valid`=1, `overflow`=0, go to IDLE.
  - Else: no strobe, `width` unchanged, go to IDLE (glitch reject).
- WAIT_LOW: stay until `s2`=0, then go to IDLE. The remainder of an overflowed pulse is never reported.
- Counter rules:
  - Unsigned, never wraps; it saturates at MAX_WIDTH.
  - A pulse of exactly MAX_WIDTH cycles reports `width`=MAX_WIDTH with `overflow`=0.
  - A pulse of MAX_WIDTH+1 or more reports with `overflow`=1.
- Back-to-back pulses:
  - A new rise can occur on the cycle immediately after `valid`, since the FSM is then in IDLE.
  - The minimum low gap between pulses for both to be measured is 1 cycle.
- Reset values:
  - `width`=0, `valid`=0, `overflow`=0, `busy`=0, state IDLE, `cnt`=0.
  - Synchronizer flops and `s2_d` reset to 1, so an input already high at reset release is not counted.
- Reset during MEASURE or WAIT_LOW aborts with no strobe. The next rising edge after reset starts a fresh measurement.

## Timing
- Input high for H sampled cycles (MIN_WIDTH≤H≤MAX_WIDTH) yields `width`=H.
- `valid` is high in the cycle following the 3rd rising clk edge after the first edge that samples `measurein` low.
- Start latency: the FSM enters MEASURE 3 edges after the first edge that samples `measurein` high. `busy` rises in that same cycle.
- Overflow: `valid`/`overflow` appear MAX_WIDTH+3 edges after the first high sample, independent of when the input falls.
- `valid` and `overflow` are registered, exactly one cycle wide, with no combinational path from `measurein`.
- `width` changes only on a `valid` cycle.

## Structure
- Package `pulse_meter_pkg`:
  - state typedef (IDLE, MEASURE, WAIT_LOW);
  - default CNT_W, MIN_WIDTH and MAX_WIDTH constants.
- Sub-module `sync_2ff`: a 2-flop synchronizer with a reset-value parameter, used here with reset value 1.
- The FSM, counter and output registers live in `pulse_width_meter` itself.

## Test plan
Bench parameters: MIN_WIDTH=4, MAX_WIDTH=100, CNT_W=8.
- Input high 10 cycles → single `valid` with `width`=10, `overflow`=0; `valid` 3 edges after the falling sample.
- Input high 3 cycles → no `valid`, `width` keeps its prior value, `busy` returns to 0.
- Input high 100 cycles → `width`=100, `overflow`=0. Input high 150 cycles → `width`=100, `overflow`=1 at edge 103; no further strobe when the input falls.
- Pulses of 5 high, 1 low, 7 high → two `valid` strobes: `width`=5, then `width`=7.
- `measurein` held high through the `rst` deassertion → no measurement until it goes low and high again. `rst` asserted 20 cycles into a pulse → no strobe; the next 8-cycle pulse reports 8.
